// File: rtl/riscv_lsu_if.sv
// Execute-stage request and data-memory port bundle for the RV32I load/store unit.
// The LSU connects to the slave modport; the driving environment connects to the master modport.
interface riscv_lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_lsu_req;
    logic            o_lsu_ready;
    logic            i_lsu_we;
    logic [2:0]      i_lsu_funct3;
    logic [XLEN-1:0] i_lsu_addr;
    logic [XLEN-1:0] i_lsu_wdata;
    logic            o_lsu_done;
    logic            o_lsu_misalign;
    logic [XLEN-1:0] o_lsu_rdata;
    logic            o_dmem_req;
    logic            o_dmem_we;
    logic [3:0]      o_dmem_be;
    logic [XLEN-1:0] o_dmem_addr;
    logic [XLEN-1:0] o_dmem_wdata;
    logic            i_dmem_ack;
    logic [XLEN-1:0] i_dmem_rdata;

    modport slave (
        input  i_lsu_req, i_lsu_we, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
        input  i_dmem_ack, i_dmem_rdata,
        output o_lsu_ready, o_lsu_done, o_lsu_misalign, o_lsu_rdata,
        output o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata
    );

    modport master (
        output i_lsu_req, i_lsu_we, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
        output i_dmem_ack, i_dmem_rdata,
        input  o_lsu_ready, o_lsu_done, o_lsu_misalign, o_lsu_rdata,
        input  o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata
    );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one access at a time, lane alignment, misalignment trap,
// and a request/acknowledge data-memory handshake.
module riscv_lsu #(
    parameter int unsigned XLEN = 32
) (
    input logic        i_clk,
    input logic        i_rst,
    riscv_lsu_if.slave lsu
);
    typedef enum logic [1:0] {StIdle, StMem, StResp, StErr} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;

    // funct3[1:0] gives the access size for loads and stores alike: 00 byte, 01 half, 1x word.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'b01 && off[0]) || (sz[1] && off != 2'b00);
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] sz, input logic [XLEN-1:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [XLEN-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   return {{(XLEN-8){b[7] & ~f3[2]}}, b};
            2'b01:   return {{(XLEN-16){h[15] & ~f3[2]}}, h};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            StIdle: begin
                if (lsu.i_lsu_req) begin
                    f3_d  = lsu.i_lsu_funct3;
                    off_d = lsu.i_lsu_addr[1:0];
                    if (is_misaligned(lsu.i_lsu_funct3[1:0], lsu.i_lsu_addr[1:0])) begin
                        state_d = StErr;
                    end else begin
                        state_d = StMem;
                        req_d   = 1'b1;
                        we_d    = lsu.i_lsu_we;
                        be_d    = lane_be(lsu.i_lsu_funct3[1:0], lsu.i_lsu_addr[1:0]);
                        addr_d  = {lsu.i_lsu_addr[XLEN-1:2], 2'b00};
                        wdata_d = lsu.i_lsu_we ?
                                  lane_wdata(lsu.i_lsu_funct3[1:0], lsu.i_lsu_wdata) : '0;
                    end
                end
            end
            StMem: begin
                if (lsu.i_dmem_ack) begin
                    state_d = StResp;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_fmt(f3_q, off_q, lsu.i_dmem_rdata);
                    end
                end
            end
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign lsu.o_lsu_ready    = (state_q == StIdle);
    assign lsu.o_lsu_done     = (state_q == StResp) || (state_q == StErr);
    assign lsu.o_lsu_misalign = (state_q == StErr);
    assign lsu.o_lsu_rdata    = rdata_q;
    assign lsu.o_dmem_req     = req_q;
    assign lsu.o_dmem_we      = we_q;
    assign lsu.o_dmem_be      = be_q;
    assign lsu.o_dmem_addr    = addr_q;
    assign lsu.o_dmem_wdata   = wdata_q;
endmodule
